// File: rtl/serial_abs_decoder_if.sv
// serial_abs_decoder_if: valid/ready bundle carrying operands in and sign/magnitude results out
interface serial_abs_decoder_if #(parameter int WIDTH = 32);
    logic             in_valid, in_ready, out_valid, out_ready, out_sign, out_min_neg;
    logic [WIDTH-1:0] in_data, out_mag;
    modport slave(input in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_sign, out_mag, out_min_neg);
    modport master(output in_valid, in_data, out_ready,
                   input in_ready, out_valid, out_sign, out_mag, out_min_neg);
endinterface

// File: rtl/serial_abs_decoder.sv
// serial_abs_decoder: bit-serial two's-complement to sign/magnitude, one bit per clock, LSB first
module serial_abs_decoder #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_abs_decoder_if.slave  io
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, mag_q, mag_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d, seen_q, seen_d, rbit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            seen_q  <= seen_d;
        end
    end
    // Negation as "copy up to and including the first 1, then invert"; positives just copy.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        seen_d  = seen_q;
        rbit    = (sign_q & seen_q) ? ~shreg_q[0] : shreg_q[0];
        case (state_q)
            IDLE: if (io.in_valid) begin
                state_d = RUN;
                shreg_d = io.in_data;
                sign_d  = io.in_data[WIDTH-1];
                cnt_d   = '0;
                seen_d  = 1'b0;
            end
            RUN: begin
                shreg_d = shreg_q >> 1;
                mag_d   = {rbit, mag_q[WIDTH-1:1]};
                seen_d  = seen_q | shreg_q[0];
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH-1)) ? DONE : RUN;
            end
            DONE:    state_d = io.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        io.in_ready  = state_q == IDLE;
        io.out_valid = state_q == DONE;
    end
    assign io.out_sign    = sign_q;
    assign io.out_mag     = mag_q;
    assign io.out_min_neg = sign_q & (mag_q == {1'b1, {(WIDTH-1){1'b0}}});
endmodule

// File: tb/tb_serial_abs_decoder.sv
// tb_serial_abs_decoder: directed vectors with hand-computed sign/magnitude results, WIDTH=32
module tb_serial_abs_decoder;
    localparam int WIDTH = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errs = 0;
    int   cyc = 0;
    int   lat, t0, t1;
    serial_abs_decoder_if #(.WIDTH(WIDTH)) io();
    serial_abs_decoder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .io(io));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (io.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic check_out(input string tag, input logic s, input logic [WIDTH-1:0] m, input logic mn);
        check({tag, " valid"}, 64'(io.out_valid), 64'd1);
        check({tag, " sign"}, 64'(io.out_sign), 64'(s));
        check({tag, " mag"}, 64'(io.out_mag), 64'(m));
        check({tag, " min_neg"}, 64'(io.out_min_neg), 64'(mn));
    endtask
    task automatic release_out(input string tag);
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        check({tag, " valid drop"}, 64'(io.out_valid), 64'd0);
        check({tag, " in_ready back"}, 64'(io.in_ready), 64'd1);
    endtask
    task automatic word(input string tag, input logic [WIDTH-1:0] d, input logic s,
                        input logic [WIDTH-1:0] m, input logic mn);
        io.in_valid = 1'b1;
        io.in_data  = d;
        check({tag, " in_ready"}, 64'(io.in_ready), 64'd1);
        @(negedge clk);
        io.in_valid = 1'b0;
        io.in_data  = 'x;
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'd32);
        check_out(tag, s, m, mn);
        release_out(tag);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        io.in_valid  = 1'b0;
        io.in_data   = 'x;
        io.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst in_ready", 64'(io.in_ready), 64'd1);
        check("rst out_valid", 64'(io.out_valid), 64'd0);
        check("rst out_sign", 64'(io.out_sign), 64'd0);
        check("rst out_mag", 64'(io.out_mag), 64'd0);
        check("rst out_min_neg", 64'(io.out_min_neg), 64'd0);
        word("neg5", 32'hFFFF_FFFB, 1'b1, 32'd5, 1'b0);
        word("pos5", 32'd5, 1'b0, 32'd5, 1'b0);
        word("zero", 32'd0, 1'b0, 32'd0, 1'b0);
        word("neg1", 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b0);
        word("minneg", 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1);
        word("maxpos", 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0);
        // backpressure with a second word offered throughout RUN and DONE
        io.in_valid = 1'b1;
        io.in_data  = 32'hFFFF_FFFB;
        @(negedge clk);
        io.in_data = 32'd9;
        wait_done(lat);
        check("bp latency", 64'(lat), 64'd32);
        check_out("bp", 1'b1, 32'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("bp hold", 1'b1, 32'd5, 1'b0);
            check("bp in_ready", 64'(io.in_ready), 64'd0);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        check("bp drop", 64'(io.out_valid), 64'd0);
        check("bp idle", 64'(io.in_ready), 64'd1);
        @(negedge clk);
        io.in_valid = 1'b0;
        io.in_data  = 'x;
        check("bp second accepted", 64'(io.in_ready), 64'd0);
        wait_done(lat);
        check("bp2 latency", 64'(lat), 64'd32);
        check_out("bp2", 1'b0, 32'd9, 1'b0);
        release_out("bp2");
        // back-to-back with out_ready held high
        io.out_ready = 1'b1;
        io.in_valid  = 1'b1;
        io.in_data   = 32'hFFFF_FFF9;
        @(negedge clk);
        t0 = cyc;
        io.in_data = 32'd7;
        wait_done(lat);
        check("b2b1 latency", 64'(lat), 64'd32);
        check_out("b2b1", 1'b1, 32'd7, 1'b0);
        @(negedge clk);
        check("b2b idle", 64'(io.in_ready), 64'd1);
        @(negedge clk);
        t1 = cyc;
        io.in_valid = 1'b0;
        io.in_data  = 'x;
        check("b2b spacing", 64'(t1 - t0), 64'd34);
        wait_done(lat);
        check("b2b2 latency", 64'(lat), 64'd32);
        check_out("b2b2", 1'b0, 32'd7, 1'b0);
        release_out("b2b2");
        // reset in the middle of RUN
        io.in_valid = 1'b1;
        io.in_data  = 32'h8000_0001;
        @(negedge clk);
        io.in_valid = 1'b0;
        io.in_data  = 'x;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort out_valid", 64'(io.out_valid), 64'd0);
        check("abort mag", 64'(io.out_mag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort in_ready", 64'(io.in_ready), 64'd1);
        check("abort idle valid", 64'(io.out_valid), 64'd0);
        word("after_abort", 32'hFFFF_FFFB, 1'b1, 32'd5, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
